// File: rtl/mod_exp_seq.sv
// Modular exponentiation sequencer: base^exponent mod MOD.
// Right-to-left square-and-multiply. One modular product is formed per clock by a single
// shared combinational Montgomery datapath (REDC with R = 2^WIDTH). That datapath is applied
// twice so its output is a plain product:
//   mont_redc(mont_redc(a*b) * R^2 mod MOD) = a*b mod MOD
// No Montgomery-domain conversion is needed around the sequencer.
// Optional feature: define MODEXP_ABORT_EN to add an `abort` input that cancels a running
// request.
// Requirements on the parameters: MOD is odd, and NPRIME = -MOD^-1 mod 2^WIDTH.

module mod_exp_seq #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  MOD       = WIDTH'(998244353),
  parameter logic [WIDTH-1:0]  NPRIME    = WIDTH'(998244351),
  parameter int unsigned       EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MODEXP_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 busy
);

  // R^2 mod MOD, folded at elaboration; scales the first REDC output back out of R^-1.
  localparam int unsigned         W2      = 2 * WIDTH + 1;
  localparam logic [W2-1:0]       RSqFull = W2'(1) << (2 * WIDTH);
  localparam logic [W2-1:0]       R2Full  = RSqFull % W2'(MOD);
  localparam logic [WIDTH-1:0]    R2      = R2Full[WIDTH-1:0];

  typedef enum logic [2:0] {StIdle, StRed, StMul, StSqr, StDone} state_e;

  state_e                 state_q;
  logic [WIDTH-1:0]       acc_q;
  logic [WIDTH-1:0]       pow_q;
  logic [EXP_WIDTH-1:0]   e_q;

  logic [WIDTH-1:0]       mul_a, mul_b, prod;

  // Operand mux for the shared multiplier, selected by the current state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StRed:   begin mul_a = pow_q; mul_b = WIDTH'(1); end  // reduces an unreduced base
      StMul:   begin mul_a = acc_q; mul_b = pow_q;     end
      StSqr:   begin mul_a = pow_q; mul_b = pow_q;     end
      default: begin mul_a = '0;    mul_b = '0;        end
    endcase
  end

  // Two chained REDC stages. Stage one gets a*b < MOD*R, because in RED b == 1 and in every
  // other state both operands are already below MOD. That bound keeps the pre-subtraction
  // value below 2*MOD, so one conditional subtract is enough.
  logic [2*WIDTH-1:0]     t1, t2;
  logic [WIDTH-1:0]       m1, m2;
  logic [2*WIDTH+1:0]     s1, s2;
  logic [WIDTH+1:0]       u1, u2;
  logic [WIDTH-1:0]       r1;

  // Montgomery datapath: r1 = a*b*R^-1 mod MOD, prod = r1*R^2*R^-1 = a*b mod MOD.
  always_comb begin
    t1   = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    m1   = t1[WIDTH-1:0] * NPRIME;
    s1   = {2'b00, t1} + ({{(WIDTH+2){1'b0}}, m1} * {{(WIDTH+2){1'b0}}, MOD});
    u1   = s1[2*WIDTH+1:WIDTH];
    r1   = (u1 >= {2'b00, MOD}) ? WIDTH'(u1 - {2'b00, MOD}) : u1[WIDTH-1:0];

    t2   = {{WIDTH{1'b0}}, r1} * {{WIDTH{1'b0}}, R2};
    m2   = t2[WIDTH-1:0] * NPRIME;
    s2   = {2'b00, t2} + ({{(WIDTH+2){1'b0}}, m2} * {{(WIDTH+2){1'b0}}, MOD});
    u2   = s2[2*WIDTH+1:WIDTH];
    prod = (u2 >= {2'b00, MOD}) ? WIDTH'(u2 - {2'b00, MOD}) : u2[WIDTH-1:0];
  end

  // Low halves of s are zero by construction; the top bits of u are zero after the subtract.
  logic unused_redc;
  assign unused_redc = ^{s1[WIDTH-1:0], s2[WIDTH-1:0], u1[WIDTH+1:WIDTH], u2[WIDTH+1:WIDTH]};

  logic abort_run;
`ifdef MODEXP_ABORT_EN
  assign abort_run = abort && (state_q inside {StRed, StMul, StSqr});
`else
  assign abort_run = 1'b0;
`endif

  // Sequencer FSM and datapath registers; abort overrides the normal transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      pow_q   <= '0;
      e_q     <= '0;
    end else if (abort_run) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            pow_q   <= base;
            acc_q   <= WIDTH'(1);
            e_q     <= exponent;
            state_q <= StRed;
          end
        end
        StRed: begin
          pow_q <= prod;
          if (e_q == '0)    state_q <= StDone;
          else if (e_q[0])  state_q <= StMul;
          else              state_q <= StSqr;
        end
        StMul: begin
          acc_q <= prod;
          if (e_q == EXP_WIDTH'(1)) state_q <= StDone;
          else                      state_q <= StSqr;
        end
        StSqr: begin
          // e_q >= 2 on every entry here, so the shifted exponent is never zero.
          pow_q   <= prod;
          e_q     <= e_q >> 1;
          state_q <= e_q[1] ? StMul : StSqr;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are straight decodes of the state register and the accumulator.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
    result    = acc_q;
  end

endmodule

// File: tb/tb_mod_exp_seq.sv
// Self-checking bench for mod_exp_seq: directed cases, Fermat check, random pairs against a
// reference model, backpressure, asynchronous reset mid-run, and abort when
// MODEXP_ABORT_EN is defined.

module tb_mod_exp_seq;

  localparam longint unsigned M = 64'd998244353;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base;
  logic [31:0] exponent;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
`ifdef MODEXP_ABORT_EN
  logic        abort;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] val;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mod_exp_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MODEXP_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base      (base),
    .exponent  (exponent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic longint unsigned ref_pow(input longint unsigned b_in,
                                              input longint unsigned e_in);
    longint unsigned r, b, e;
    r = 1;
    b = b_in % M;
    e = e_in;
    while (e != 0) begin
      if (e[0]) r = (r * b) % M;
      b = (b * b) % M;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [31:0] e);
    int msb;
    if (e == 0) return 2;
    msb = 0;
    for (int i = 0; i < 32; i++) if (e[i]) msb = i;
    return 2 + $countones(e) + msb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one request and push its expected result and latency.
  task automatic send(input logic [31:0] b, input logic [31:0] e);
    exp_t x;
    int   w;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1;
    base     = b;
    exponent = e;
    x.val = 32'(ref_pow(longint'(b), longint'(e)));
    x.lat = ref_lat(e);
    sb.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, compare value and latency, optionally stall for `hold` cycles
  // while pulsing in_valid, then complete the output handshake.
  task automatic collect(input string tag, input int hold);
    int   cycles;
    exp_t x;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 100) begin @(posedge clk); #1; cycles++; end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_val"}, 64'(result), 64'(x.val));
      chk({tag, "_lat"}, 64'(cycles + 1), 64'(x.lat));
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        base     = $urandom;
        exponent = $urandom;
        @(posedge clk); #1;
        chk({tag, "_hold_val"}, 64'(result), 64'(x.val));
        chk({tag, "_hold_ov"}, 64'(out_valid), 64'd1);
        chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
      chk({tag, "_idle_ov"}, 64'(out_valid), 64'd0);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ov"}, 64'(out_valid), 64'd0);
    chk({tag, "_res"}, 64'(result), 64'd0);
  endtask

  initial begin
    logic [31:0] rb, re;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    base      = '0;
    exponent  = '0;
`ifdef MODEXP_ABORT_EN
    abort     = 1'b0;
`endif
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post_reset");

    // Directed cases, including the zero-exponent and unreduced-base boundaries.
    send(32'd2, 32'd10);                  collect("p2_10", 0);
    send(32'd3, 32'd0);                   collect("p3_0", 0);
    send(32'd0, 32'd0);                   collect("p0_0", 0);
    send(32'd0, 32'd5);                   collect("p0_5", 0);
    send(32'(M + 5), 32'd1);              collect("pMp5_1", 0);
    send(32'(M - 1), 32'd2);              collect("pMm1_2", 0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);   collect("pmax", 0);
    send(32'd3, 32'(M - 1));              collect("fermat", 0);
    chk("fermat_one", 64'(ref_pow(64'd3, M - 1)), 64'd1);

    // Backpressure: ten stalled cycles in DONE with in_valid pulses that must be ignored.
    send(32'd5, 32'd3);                   collect("bp", 10);

    // Random base/exponent pairs; exponent width varies so latencies spread out.
    for (int n = 0; n < 200; n++) begin
      rb = $urandom;
      re = $urandom >> $urandom_range(0, 31);
      send(rb, re);
      collect("rand", 0);
    end

    // Asynchronous reset while squaring 2^(2^31).
    send(32'd2, 32'h8000_0000);
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'd7, 32'd13);                  collect("after_rst", 0);

`ifdef MODEXP_ABORT_EN
    // Abort in MUL: 3^7 goes RED, MUL, ... so one cycle after acceptance the FSM is in MUL.
    send(32'd3, 32'd7);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_rdy", 64'(in_ready), 64'd1);
    chk("abort_ov", 64'(out_valid), 64'd0);
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_out", 64'(out_valid), 64'd0);
    end
    send(32'd3, 32'd7);                   collect("after_abort", 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
